// File: rtl/multi_fifo_pkg.sv
// Shared types and helpers for the multi-port bundle FIFO.
package multi_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

  typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

  // Pointer advance modulo FIFO_DEPTH (power of two, so truncation wraps).
  function automatic fifo_ptr_t wrap_add(fifo_ptr_t ptr, fifo_cnt_t n);
    fifo_cnt_t sum;
    sum = {1'b0, ptr} + n;
    return sum[FIFO_PTR_W-1:0];
  endfunction

endpackage

// File: rtl/multi_port_fifo_count_one.sv
// Lane counter: number of set bits, or (CONTINUOUS=1) length of the run of 1s from bit 0.
module count_one #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic [WIDTH-1:0]             in_vec,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (CONTINUOUS) begin
        run = run & in_vec[i];
        if (run) cnt = cnt + CW'(1);
      end else if (in_vec[i]) begin
        cnt = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-lane bundle FIFO: all-or-nothing push of up to IN_PORTS entries, partial pop of up to OUT_PORTS.
// Define MULTI_FIFO_FREE_COUNT_EN to add the registered free_count output.
module multi_port_fifo
  import multi_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [IN_PORTS-1:0]            push_valid,
  input  logic [IN_PORTS*WIDTH-1:0]      push_data,
  output logic                           push_ready,
  output logic [OUT_PORTS-1:0]           out_valid,
  output logic [OUT_PORTS*WIDTH-1:0]     out_data,
  input  logic [OUT_PORTS-1:0]           pop_accept
`ifdef MULTI_FIFO_FREE_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]         free_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PC_W  = $clog2(IN_PORTS + 1);
  localparam int unsigned PO_W  = $clog2(OUT_PORTS + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PC_W-1:0]  push_cnt;
  logic [PO_W-1:0]  pop_cnt;

  count_one #(.WIDTH(IN_PORTS), .CONTINUOUS(1'b1)) u_push_cnt (
    .in_vec (push_valid),
    .cnt    (push_cnt)
  );

  count_one #(.WIDTH(OUT_PORTS), .CONTINUOUS(1'b1)) u_pop_cnt (
    .in_vec (pop_accept & out_valid),
    .cnt    (pop_cnt)
  );

  // Free space is judged on the start-of-cycle count; same-cycle pops do not help.
  always_comb begin
    push_ready = !flush && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(push_cnt));
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
      wr_ptr_d = wr_ptr_q + (push_ready ? PTR_W'(push_cnt) : '0);
      count_d  = count_q + (push_ready ? CNT_W'(push_cnt) : '0) - CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < IN_PORTS; i++) begin
      if (push_ready && (PC_W'(i) < push_cnt)) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= push_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int unsigned i = 0; i < OUT_PORTS; i++) begin
      out_valid[i]               = (CNT_W'(i) < count_q);
      out_data[i*WIDTH +: WIDTH] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

`ifdef MULTI_FIFO_FREE_COUNT_EN
  logic [CNT_W-1:0] free_q, free_d;

  always_comb begin
    free_d = CNT_W'(DEPTH) - count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= CNT_W'(DEPTH);
    end else begin
      free_q <= free_d;
    end
  end

  assign free_count = free_q;
`else
`endif

endmodule
